reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement ring with CDB writeback, operand lookup
// and branch-mispredict flush. Optional macro: ROB_CDB_BYPASS_EN.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (low = freeze)
//   issue_*      : allocate tail entry; rob_full when all entries in use
//   new_reg_id / new_ROB_id      : rename request (id = tail)
//   write_reg_id / write_ROB_id / write_val, real_commit, commit_store
//                                : retirement from head
//   rs1_/rs2_id -> rsN_ready / rsN_val : operand lookups
//   cdb_*        : result broadcast (branch: val = next PC, jump = taken)
//   clear_flag / clear_pc        : one-cycle flush pulse and redirect PC
module reorder_buffer #(
    parameter int ROB_WIDTH_BIT = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,

    input  logic                     issue_valid,
    input  logic [1:0]               issue_type,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_ready,
    input  logic [31:0]              issue_val,
    input  logic                     issue_pred_jump,
    output logic                     rob_full,

    output logic [4:0]               new_reg_id,
    output logic [ROB_WIDTH_BIT-1:0] new_ROB_id,

    output logic [4:0]               write_reg_id,
    output logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
    output logic [31:0]              write_val,
    output logic                     real_commit,
    output logic                     commit_store,

    input  logic [ROB_WIDTH_BIT-1:0] rs1_id,
    input  logic [ROB_WIDTH_BIT-1:0] rs2_id,
    output logic                     rs1_ready,
    output logic                     rs2_ready,
    output logic [31:0]              rs1_val,
    output logic [31:0]              rs2_val,

    input  logic                     cdb_valid,
    input  logic [ROB_WIDTH_BIT-1:0] cdb_rob_id,
    input  logic [31:0]              cdb_val,
    input  logic                     cdb_jump,

    output logic                     clear_flag,
    output logic [31:0]              clear_pc
);

    localparam int DEPTH = 1 << ROB_WIDTH_BIT;
    localparam logic [1:0] T_REG    = 2'd0;
    localparam logic [1:0] T_STORE  = 2'd1;
    localparam logic [1:0] T_BRANCH = 2'd2;
    localparam logic [ROB_WIDTH_BIT:0] FULL_CNT =
        {1'b1, {ROB_WIDTH_BIT{1'b0}}};
    localparam logic [ROB_WIDTH_BIT:0] ONE_CNT =
        {{ROB_WIDTH_BIT{1'b0}}, 1'b1};

    logic [DEPTH-1:0]         busy_q;
    logic [DEPTH-1:0]         ready_q;
    logic [DEPTH-1:0]         pj_q;
    logic [DEPTH-1:0]         jump_q;
    logic [1:0]               type_q [DEPTH];
    logic [4:0]               rd_q   [DEPTH];
    logic [31:0]              val_q  [DEPTH];

    logic [ROB_WIDTH_BIT-1:0] head_q;
    logic [ROB_WIDTH_BIT-1:0] tail_q;
    logic [ROB_WIDTH_BIT:0]   count_q;
    logic                     clear_q;
    logic [31:0]              clear_pc_q;

    logic issue_ok;
    logic commit_ok;
    logic cdb_ok;
    logic mispredict;

    // A pending flush blocks every state update for its cycle.
    always_comb begin
        rob_full   = (count_q == FULL_CNT);
        issue_ok   = rdy_in && !clear_q && issue_valid && !rob_full;
        commit_ok  = rdy_in && !clear_q
                     && busy_q[head_q] && ready_q[head_q];
        cdb_ok     = rdy_in && !clear_q && cdb_valid
                     && busy_q[cdb_rob_id];
        mispredict = commit_ok && (type_q[head_q] == T_BRANCH)
                     && (jump_q[head_q] != pj_q[head_q]);
    end

    always_comb begin
        new_ROB_id   = tail_q;
        new_reg_id   = 5'd0;
        if (issue_ok && issue_type == T_REG)
            new_reg_id = issue_rd;

        write_ROB_id = head_q;
        real_commit  = commit_ok;
        commit_store = commit_ok && (type_q[head_q] == T_STORE);
        write_reg_id = 5'd0;
        write_val    = 32'd0;
        if (commit_ok) begin
            write_val = val_q[head_q];
            if (type_q[head_q] == T_REG)
                write_reg_id = rd_q[head_q];
        end

        clear_flag = clear_q && rdy_in;
        clear_pc   = clear_flag ? clear_pc_q : 32'd0;
    end

    always_comb begin
        rs1_ready = busy_q[rs1_id] && ready_q[rs1_id];
        rs1_val   = rs1_ready ? val_q[rs1_id] : 32'd0;
        rs2_ready = busy_q[rs2_id] && ready_q[rs2_id];
        rs2_val   = rs2_ready ? val_q[rs2_id] : 32'd0;
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_valid && rs1_id == cdb_rob_id) begin
            rs1_ready = 1'b1;
            rs1_val   = cdb_val;
        end
        if (cdb_valid && rs2_id == cdb_rob_id) begin
            rs2_ready = 1'b1;
            rs2_val   = cdb_val;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q     <= '0;
            ready_q    <= '0;
            pj_q       <= '0;
            jump_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            clear_q    <= 1'b0;
            clear_pc_q <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                type_q[i] <= 2'd0;
                rd_q[i]   <= 5'd0;
                val_q[i]  <= 32'd0;
            end
        end else if (rdy_in) begin
            if (clear_q) begin
                clear_q <= 1'b0;
            end else begin
                if (cdb_ok) begin
                    ready_q[cdb_rob_id] <= 1'b1;
                    val_q[cdb_rob_id]   <= cdb_val;
                    jump_q[cdb_rob_id]  <= cdb_jump;
                end
                if (issue_ok) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= issue_ready;
                    type_q[tail_q]  <= issue_type;
                    rd_q[tail_q]    <= issue_rd;
                    val_q[tail_q]   <= issue_ready ? issue_val : 32'd0;
                    pj_q[tail_q]    <= issue_pred_jump;
                    jump_q[tail_q]  <= 1'b0;
                    tail_q          <= tail_q + 1'b1;
                end
                if (commit_ok) begin
                    busy_q[head_q] <= 1'b0;
                    head_q         <= head_q + 1'b1;
                end
                if (issue_ok && !commit_ok)
                    count_q <= count_q + ONE_CNT;
                else if (!issue_ok && commit_ok)
                    count_q <= count_q - ONE_CNT;
                // Later assignments override the updates above: the
                // ring is emptied the moment the bad branch retires.
                if (mispredict) begin
                    busy_q     <= '0;
                    head_q     <= '0;
                    tail_q     <= '0;
                    count_q    <= '0;
                    clear_q    <= 1'b1;
                    clear_pc_q <= val_q[head_q];
                end
            end
        end
    end

endmodule
